sysref_gate_mon: RTL

- SYSREF gate and monitor in the rfdc_clk domain.
- Sits directly downstream of the SYSREF capture stage and feeds the RFDC SYSREF input.
- Opens the path only on a clean low phase, so the RFDC never sees a runt pulse. It then passes either a programmed number of whole pulses or a continuous stream until closed.
- Independently measures the SYSREF period and flags deviations from the expected value.

---
 rtl/sysref_gate_pkg.sv | 20 ++
 rtl/sysref_period_mon.sv | 53 +++++
 rtl/sysref_gate_mon.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sysref_gate_pkg.sv
// Shared types and defaults for the SYSREF gate/monitor slice.
// Latency: n/a (types only); no backpressure.
package sysref_gate_pkg;

    localparam int COUNT_W_DEF  = 8;
    localparam int PERIOD_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_OPEN  = 2'd2,
        ST_CLOSE = 2'd3
    } gate_state_t;

    // CLOSE keeps passing so an in-flight pulse is never truncated.
    function automatic logic gate_passes(input gate_state_t st);
        return (st == ST_OPEN) || (st == ST_CLOSE);
    endfunction

endpackage

// File: rtl/sysref_period_mon.sv
// SYSREF rise-to-rise period measurement with sticky mismatch flag.
// Latency: results update the cycle after the rise strobe; no backpressure.
module sysref_period_mon
    import sysref_gate_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                rfdc_clk,
    input  logic                rfdc_rst,
    input  logic                rise,
    input  logic [PERIOD_W-1:0] exp_period,
    input  logic                err_clear,
    output logic [PERIOD_W-1:0] period_meas,
    output logic                period_valid,
    output logic                period_err
);

    logic [PERIOD_W-1:0] period_cnt;
    logic                rise_seen;
    logic                mismatch;
    logic                err_set;

    // A saturated count is a lost period, never a match, even against all-ones.
    assign mismatch = (period_cnt != exp_period) || (period_cnt == '1);
    assign err_set  = rise && rise_seen && (exp_period != '0) && mismatch;

    always_ff @(posedge rfdc_clk) begin
        if (rfdc_rst) begin
            period_cnt   <= '0;
            rise_seen    <= 1'b0;
            period_meas  <= '0;
            period_valid <= 1'b0;
            period_err   <= 1'b0;
        end else begin
            period_valid <= rise && rise_seen;
            if (rise) begin
                period_cnt <= PERIOD_W'(1);
                rise_seen  <= 1'b1;
                if (rise_seen) begin
                    period_meas <= period_cnt;
                end
            end else if (period_cnt != '1) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
            if (err_set) begin
                period_err <= 1'b1;
            end else if (err_clear) begin
                period_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sysref_gate_mon.sv
// SYSREF gate (whole pulses only, counted or continuous) plus optional period monitor (SYSREF_PERIOD_MON_EN).
// Latency: sysref_in to sysref_out 1 cycle; no backpressure.
module sysref_gate_mon
    import sysref_gate_pkg::*;
#(
    parameter int COUNT_W  = COUNT_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                rfdc_clk,
    input  logic                rfdc_rst,
    input  logic                sysref_in,
    input  logic                arm,
    input  logic                disarm,
    input  logic                continuous,
    input  logic [COUNT_W-1:0]  pulse_count,
    input  logic [PERIOD_W-1:0] exp_period,
    input  logic                err_clear,
    output logic                sysref_out,
    output logic                busy,
    output logic                pulses_done,
    output logic [PERIOD_W-1:0] period_meas,
    output logic                period_valid,
    output logic                period_err
);

    gate_state_t        state;
    gate_state_t        state_nxt;
    logic               sysref_d;
    logic               rise;
    logic               fall;
    logic               cont_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] pulse_cnt;
    logic [COUNT_W-1:0] pulse_cnt_inc;
    logic               load_req;
    logic               cnt_inc;
    logic               done_nxt;

    assign rise          = sysref_in & ~sysref_d;
    assign fall          = ~sysref_in & sysref_d;
    assign pulse_cnt_inc = pulse_cnt + COUNT_W'(1);
    assign busy          = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        cnt_inc   = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // disarm beats arm; a zero-length counted burst is a no-op.
                if (arm && !disarm && (continuous || (pulse_count != '0))) begin
                    load_req  = 1'b1;
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (disarm) begin
                    state_nxt = ST_IDLE;
                end else if (!sysref_in) begin
                    state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (fall) begin
                    cnt_inc = 1'b1;
                end
                if (fall && !cont_q && (pulse_cnt_inc == count_q)) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (disarm) begin
                    state_nxt = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (!sysref_in) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge rfdc_clk) begin
        if (rfdc_rst) begin
            state       <= ST_IDLE;
            sysref_d    <= 1'b0;
            cont_q      <= 1'b0;
            count_q     <= '0;
            pulse_cnt   <= '0;
            sysref_out  <= 1'b0;
            pulses_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            sysref_d    <= sysref_in;
            sysref_out  <= sysref_in & gate_passes(state);
            pulses_done <= done_nxt;
            if (load_req) begin
                cont_q    <= continuous;
                count_q   <= pulse_count;
                pulse_cnt <= '0;
            end else if (cnt_inc) begin
                pulse_cnt <= pulse_cnt_inc;
            end
        end
    end

`ifdef SYSREF_PERIOD_MON_EN
    sysref_period_mon #(
        .PERIOD_W (PERIOD_W)
    ) u_period_mon (
        .rfdc_clk     (rfdc_clk),
        .rfdc_rst     (rfdc_rst),
        .rise         (rise),
        .exp_period   (exp_period),
        .err_clear    (err_clear),
        .period_meas  (period_meas),
        .period_valid (period_valid),
        .period_err   (period_err)
    );
`else
    logic unused_mon_inputs;
    assign unused_mon_inputs = ^{exp_period, err_clear, rise};
    assign period_meas       = '0;
    assign period_valid      = 1'b0;
    assign period_err        = 1'b0;
`endif

endmodule
